// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: radix-2 restoring divide sequencer for DIV/DIVU (quotient->LO, remainder->HI)
//   clk, reset (async, active-high)
//   div_start, div_signed, div_cancel, dividend, divisor : request side
//   div_busy (in CALC), div_complete (one-cycle pulse), quotient, remainder : result side
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic             div_cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_busy,
    output logic             div_complete,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] aq, dvs, dvd_raw;
    logic             neg_q, neg_r, dz;
    logic             accept, ge;
    logic [WIDTH:0]   p_sh, p_nx;
    logic [WIDTH-1:0] aq_nx, q_fin, r_fin, a_abs, b_abs;
    assign div_busy     = state == S_CALC;
    assign div_complete = state == S_DONE;
    assign accept = div_start && !div_cancel && (state == S_IDLE || state == S_DONE);
    // aq holds the unconsumed dividend bits in its top and the growing quotient in its bottom
    always_comb begin
        a_abs = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        b_abs = (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;
        p_sh  = {p[WIDTH-1:0], aq[WIDTH-1]};
        ge    = p_sh >= {1'b0, dvs};
        p_nx  = ge ? p_sh - {1'b0, dvs} : p_sh;
        aq_nx = {aq[WIDTH-2:0], ge};
        q_fin = dz ? '1 : neg_q ? -aq_nx : aq_nx;
        r_fin = dz ? dvd_raw : neg_r ? -p_nx[WIDTH-1:0] : p_nx[WIDTH-1:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            p         <= '0;
            aq        <= '0;
            dvs       <= '0;
            dvd_raw   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            state   <= S_CALC;
            cnt     <= '0;
            p       <= '0;
            aq      <= a_abs;
            dvs     <= b_abs;
            dvd_raw <= dividend;
            neg_q   <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= div_signed && dividend[WIDTH-1];
            dz      <= divisor == '0;
        end else if (state == S_CALC) begin
            if (div_cancel) begin
                state <= S_IDLE;
            end else begin
                p   <= p_nx;
                aq  <= aq_nx;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state     <= S_DONE;
                    quotient  <= q_fin;
                    remainder <= r_fin;
                end
            end
        end else begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed self-checking bench for div_seq_ctrl
module tb_div_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic        div_cancel = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_busy, div_complete;
    logic [31:0] quotient, remainder;
    int errors = 0;
    int checks = 0;

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .div_start(div_start), .div_signed(div_signed),
        .div_cancel(div_cancel), .dividend(dividend), .divisor(divisor),
        .div_busy(div_busy), .div_complete(div_complete),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_start  = 1'b1;
        step();
        div_start  = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        div_signed = 1'($urandom);
    endtask

    // Called right after the start edge (cycle 1); returns the cycle index where complete is seen
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!div_complete && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er);
        int cyc;
        start(a, b, s);
        wait_done(cyc);
        checks++;
        if (cyc !== 33) begin errors++; $display("FAIL %s latency got %0d want 33", name, cyc); end
        checks++;
        if (quotient !== eq) begin errors++; $display("FAIL %s quotient got %h want %h", name, quotient, eq); end
        checks++;
        if (remainder !== er) begin errors++; $display("FAIL %s remainder got %h want %h", name, remainder, er); end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({div_busy, div_complete} !== 2'b00) begin errors++; $display("FAIL reset flags got %b want 00", {div_busy, div_complete}); end
        checks++;
        if ({quotient, remainder} !== 64'd0) begin errors++; $display("FAIL reset results got %h/%h want 0/0", quotient, remainder); end
        step();
        step();
        #2 reset = 1'b0;
        step();
        checks++;
        if (div_busy !== 1'b0) begin errors++; $display("FAIL reset idle busy got %b want 0", div_busy); end
    endtask

    task automatic test_unsigned();
        int bad = 0;
        start(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 32; c++) begin
            if (div_busy !== 1'b1 || div_complete !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL divu busy_window bad cycles got %0d want 0", bad); end
        checks++;
        if ({div_busy, div_complete} !== 2'b01) begin errors++; $display("FAIL divu cycle33 busy/complete got %b want 01", {div_busy, div_complete}); end
        checks++;
        if (quotient !== 32'd14) begin errors++; $display("FAIL divu quotient got %0d want 14", quotient); end
        checks++;
        if (remainder !== 32'd2) begin errors++; $display("FAIL divu remainder got %0d want 2", remainder); end
        step();
        checks++;
        if (div_complete !== 1'b0) begin errors++; $display("FAIL divu pulse_width complete got %b want 0", div_complete); end
        do_div("divu_big", 32'hFFFFFFFF, 32'h00010000, 1'b0, 32'h0000FFFF, 32'h0000FFFF);
    endtask

    task automatic test_signed();
        do_div("div_neg7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
        do_div("div_7_neg2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1);
        do_div("div_min_neg1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0);
        do_div("divu_neg7_2", 32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1);
    endtask

    task automatic test_div_zero();
        do_div("divu_by_zero", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5);
        do_div("div_by_zero", 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB);
    endtask

    task automatic test_cancel();
        int seen = 0;
        do_div("cancel_prior", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        start(32'hFFFFFFFF, 32'd1, 1'b0);
        for (int c = 1; c < 10; c++) step();
        div_cancel = 1'b1;
        step();
        div_cancel = 1'b0;
        checks++;
        if (div_busy !== 1'b0) begin errors++; $display("FAIL cancel busy cycle11 got %b want 0", div_busy); end
        for (int c = 0; c < 40; c++) begin
            if (div_complete) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL cancel stray_complete got %0d want 0", seen); end
        checks++;
        if ({quotient, remainder} !== {32'd14, 32'd2}) begin errors++; $display("FAIL cancel held got %0d/%0d want 14/2", quotient, remainder); end
        div_cancel = 1'b1;
        start(32'd50, 32'd5, 1'b0);
        div_cancel = 1'b0;
        checks++;
        if (div_busy !== 1'b0) begin errors++; $display("FAIL cancel idle_block busy got %b want 0", div_busy); end
        step();
        checks++;
        if (div_busy !== 1'b0) begin errors++; $display("FAIL cancel idle_block later busy got %b want 0", div_busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start(32'd100, 32'd7, 1'b0);
        wait_done(cyc);
        checks++;
        if ({quotient, remainder} !== {32'd14, 32'd2}) begin errors++; $display("FAIL b2b first got %0d/%0d want 14/2", quotient, remainder); end
        start(32'd9, 32'd3, 1'b0);
        checks++;
        if ({div_busy, div_complete} !== 2'b10) begin errors++; $display("FAIL b2b rebusy got %b want 10", {div_busy, div_complete}); end
        for (int c = 1; c < 10; c++) step();
        start(32'd50, 32'd5, 1'b0);
        cyc = 11;
        while (!div_complete && cyc < 40) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc !== 33) begin errors++; $display("FAIL b2b latency got %0d want 33", cyc); end
        checks++;
        if ({quotient, remainder} !== {32'd3, 32'd0}) begin errors++; $display("FAIL b2b second got %0d/%0d want 3/0", quotient, remainder); end
        step();
        checks++;
        if ({div_busy, div_complete} !== 2'b00) begin errors++; $display("FAIL b2b idle_after got %b want 00", {div_busy, div_complete}); end
    endtask

    task automatic test_async_reset();
        int seen = 0;
        start(32'd100, 32'd7, 1'b0);
        for (int c = 1; c < 15; c++) step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({div_busy, div_complete} !== 2'b00) begin errors++; $display("FAIL areset flags got %b want 00", {div_busy, div_complete}); end
        checks++;
        if ({quotient, remainder} !== 64'd0) begin errors++; $display("FAIL areset results got %h/%h want 0/0", quotient, remainder); end
        step();
        #2 reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (div_complete || div_busy) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL areset activity got %0d want 0", seen); end
        do_div("areset_after", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
